// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment capture path.
//   seg_t      : 7-bit segment pattern {a,b,c,d,e,f,g}, a = bit 6
//   nibble_t   : decoded hex digit
//   SEG_*      : the sixteen legal glyphs
//   rd_state_t : reader state machine encoding
package sevenseg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] nibble_t;

    localparam seg_t SEG_0 = 7'b1111110;
    localparam seg_t SEG_1 = 7'b0110000;
    localparam seg_t SEG_2 = 7'b1101101;
    localparam seg_t SEG_3 = 7'b1111001;
    localparam seg_t SEG_4 = 7'b0110011;
    localparam seg_t SEG_5 = 7'b1011011;
    localparam seg_t SEG_6 = 7'b1011111;
    localparam seg_t SEG_7 = 7'b1110000;
    localparam seg_t SEG_8 = 7'b1111111;
    localparam seg_t SEG_9 = 7'b1110011;
    localparam seg_t SEG_A = 7'b1110111;
    localparam seg_t SEG_B = 7'b0011111;
    localparam seg_t SEG_C = 7'b1001110;
    localparam seg_t SEG_D = 7'b0111101;
    localparam seg_t SEG_E = 7'b1001111;
    localparam seg_t SEG_F = 7'b1000111;

    typedef enum logic [1:0] {
        WAIT  = 2'd0,
        COUNT = 2'd1,
        HELD  = 2'd2
    } rd_state_t;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational glyph decoder: segment pattern -> hex nibble.
//   segments : input pattern {a..g}
//   nibble   : decoded value (0 when the pattern is not a glyph)
//   legal    : 1 when the pattern matches one of the sixteen glyphs
module seg_to_hex
    import sevenseg_pkg::*;
(
    input  seg_t    segments,
    output nibble_t nibble,
    output logic    legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        unique case (segments)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevenseg_reader.sv
// Monitors a multiplexed seven-segment bus and rebuilds the displayed value.
// A strobed pattern is captured once digit_en and segments have been
// identical for STABLE_CYCLES consecutive cycles.
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   digit_en    : one-hot digit strobe (anything else is ignored)
//   segments    : shared segment pattern {a..g}
//   value       : captured nibbles, digit i at [4i+3:4i]
//   digit_valid : digit i holds a legally decoded nibble
//   frame_done  : one-cycle pulse once every digit has been captured
//   bad_pattern : one-cycle pulse when a stable pattern is not a glyph
module sevenseg_reader
    import sevenseg_pkg::*;
#(
    parameter int NDIGITS       = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NDIGITS-1:0]     digit_en,
    input  seg_t                   segments,
    output logic [4*NDIGITS-1:0]   value,
    output logic [NDIGITS-1:0]     digit_valid,
    output logic                   frame_done,
    output logic                   bad_pattern
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(STABLE_CYCLES);

    rd_state_t              state_reg, state_next;
    logic [CW-1:0]          count_reg, count_next;
    logic [NDIGITS-1:0]     prev_en_reg;
    seg_t                   prev_seg_reg;
    logic [NDIGITS-1:0]     seen_reg;
    logic                   frame_done_reg;
    logic                   bad_pattern_reg;

    logic                   one_hot;
    logic                   same;
    logic                   capture;
    nibble_t                nibble;
    logic                   legal;
    logic [NDIGITS-1:0]     seen_merged;
    logic                   frame_hit;

    seg_to_hex u_dec (
        .segments (segments),
        .nibble   (nibble),
        .legal    (legal)
    );

    assign one_hot = $onehot(digit_en);
    assign same    = (digit_en == prev_en_reg) && (segments == prev_seg_reg);

    // Next-state: any non-one-hot strobe drops straight to WAIT; any change
    // of a one-hot input restarts the count at 1 (the new value has been
    // present for one cycle already).
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        capture    = 1'b0;
        if (!one_hot) begin
            state_next = WAIT;
            count_next = '0;
        end else begin
            case (state_reg)
                WAIT: begin
                    state_next = COUNT;
                    count_next = CNT_ONE;
                end
                COUNT: begin
                    if (!same) begin
                        count_next = CNT_ONE;
                    end else if (count_reg >= CNT_LAST) begin
                        capture    = 1'b1;
                        state_next = HELD;
                        count_next = CNT_FULL;
                    end else begin
                        count_next = count_reg + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_next = COUNT;
                        count_next = CNT_ONE;
                    end
                end
                default: begin
                    state_next = WAIT;
                    count_next = '0;
                end
            endcase
        end
    end

    // Only legal captures mark a digit as seen; the frame closes in the
    // same edge as the capture that completes the mask.
    assign seen_merged = seen_reg | ((capture && legal) ? digit_en : '0);
    assign frame_hit   = capture && legal && (&seen_merged);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= WAIT;
            count_reg       <= '0;
            prev_en_reg     <= '0;
            prev_seg_reg    <= '0;
            seen_reg        <= '0;
            frame_done_reg  <= 1'b0;
            bad_pattern_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            prev_en_reg     <= digit_en;
            prev_seg_reg    <= segments;
            seen_reg        <= frame_hit ? '0 : seen_merged;
            frame_done_reg  <= frame_hit;
            bad_pattern_reg <= capture && !legal;
        end
    end

    // Per-digit storage: an illegal capture keeps the old nibble but
    // withdraws its valid flag.
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
        nibble_t nib_reg;
        logic    valid_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                nib_reg   <= '0;
                valid_reg <= 1'b0;
            end else if (capture && digit_en[gi]) begin
                if (legal) begin
                    nib_reg <= nibble;
                end
                valid_reg <= legal;
            end
        end

        assign value[4*gi +: 4] = nib_reg;
        assign digit_valid[gi]  = valid_reg;
    end

    assign frame_done  = frame_done_reg;
    assign bad_pattern = bad_pattern_reg;

endmodule

// File: tb/tb_sevenseg_reader.sv
module tb_sevenseg_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  digit_en;
    logic [6:0]  segments;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        bad_pattern;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int bp_cnt   = 0;

    sevenseg_reader #(.NDIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit_en    (digit_en),
        .segments    (segments),
        .value       (value),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern)
    );

    always #5 clk = ~clk;

    // Apply inputs and hold them for n rising edges, counting pulses seen.
    task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
        digit_en = en;
        segments = seg;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) fd_cnt++;
            if (bad_pattern === 1'b1) bp_cnt++;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        digit_en = 4'b0000;
        segments = 7'b0000000;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL reset_value: got %h expected %h", value, 16'h0000); end
        n_checks++; if (digit_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", digit_valid, 4'b0000); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        n_checks++; if (bad_pattern !== 1'b0) begin n_fail++; $display("FAIL reset_bad_pattern: got %b expected 0", bad_pattern); end
        reset  = 1'b0;
        fd_cnt = 0;
        bp_cnt = 0;
        hold(4'b0000, 7'b0000000, 20);
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL idle_value: got %h expected %h", value, 16'h0000); end
        n_checks++; if (digit_valid !== 4'b0000) begin n_fail++; $display("FAIL idle_valid: got %b expected %b", digit_valid, 4'b0000); end
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL idle_frame_pulses: got %0d expected 0", fd_cnt); end
        n_checks++; if (bp_cnt !== 0) begin n_fail++; $display("FAIL idle_bad_pulses: got %0d expected 0", bp_cnt); end
        $display("test_reset done: value=%h valid=%b", value, digit_valid);
    endtask

    task automatic test_single_digit();
        hold(4'b0001, 7'b1111001, 3);
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL single_early: got %h expected %h", value, 16'h0000); end
        hold(4'b0001, 7'b1111001, 1);
        n_checks++; if (value !== 16'h0003) begin n_fail++; $display("FAIL single_value: got %h expected %h", value, 16'h0003); end
        n_checks++; if (digit_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b expected %b", digit_valid, 4'b0001); end
        hold(4'b0001, 7'b1111001, 10);
        n_checks++; if (value !== 16'h0003) begin n_fail++; $display("FAIL single_hold_value: got %h expected %h", value, 16'h0003); end
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL single_frame_pulses: got %0d expected 0", fd_cnt); end
        n_checks++; if (bp_cnt !== 0) begin n_fail++; $display("FAIL single_bad_pulses: got %0d expected 0", bp_cnt); end
        $display("test_single_digit done: value=%h valid=%b", value, digit_valid);
    endtask

    task automatic test_full_frame();
        fd_cnt = 0;
        hold(4'b0001, 7'b1110111, 4);
        hold(4'b0010, 7'b0011111, 4);
        hold(4'b0100, 7'b1001110, 4);
        hold(4'b1000, 7'b0111101, 3);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_early: got %b expected 0", frame_done); end
        hold(4'b1000, 7'b0111101, 1);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_pulse: got %b expected 1", frame_done); end
        n_checks++; if (value !== 16'hDCBA) begin n_fail++; $display("FAIL frame_value: got %h expected %h", value, 16'hDCBA); end
        n_checks++; if (digit_valid !== 4'b1111) begin n_fail++; $display("FAIL frame_valid: got %b expected %b", digit_valid, 4'b1111); end
        hold(4'b1000, 7'b0111101, 1);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_pulse_end: got %b expected 0", frame_done); end
        n_checks++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL frame_pulse_count: got %0d expected 1", fd_cnt); end
        $display("test_full_frame done: value=%h valid=%b", value, digit_valid);
    endtask

    task automatic test_glitch();
        bp_cnt = 0;
        hold(4'b0010, 7'b1011011, 3);
        hold(4'b0010, 7'b0110000, 1);
        n_checks++; if (value[7:4] !== 4'hB) begin n_fail++; $display("FAIL glitch_no5: got %h expected %h", value[7:4], 4'hB); end
        hold(4'b0010, 7'b0110000, 1);
        n_checks++; if (value[7:4] !== 4'hB) begin n_fail++; $display("FAIL glitch_early: got %h expected %h", value[7:4], 4'hB); end
        hold(4'b0010, 7'b0110000, 3);
        n_checks++; if (value !== 16'hDC1A) begin n_fail++; $display("FAIL glitch_value: got %h expected %h", value, 16'hDC1A); end
        n_checks++; if (bp_cnt !== 0) begin n_fail++; $display("FAIL glitch_bad_pulses: got %0d expected 0", bp_cnt); end
        $display("test_glitch done: value=%h valid=%b", value, digit_valid);
    endtask

    task automatic test_illegal_overlap();
        bp_cnt = 0;
        fd_cnt = 0;
        hold(4'b0100, 7'b0000001, 3);
        n_checks++; if (bad_pattern !== 1'b0) begin n_fail++; $display("FAIL illegal_early: got %b expected 0", bad_pattern); end
        hold(4'b0100, 7'b0000001, 1);
        n_checks++; if (bad_pattern !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse: got %b expected 1", bad_pattern); end
        n_checks++; if (digit_valid !== 4'b1011) begin n_fail++; $display("FAIL illegal_valid: got %b expected %b", digit_valid, 4'b1011); end
        n_checks++; if (value !== 16'hDC1A) begin n_fail++; $display("FAIL illegal_value: got %h expected %h", value, 16'hDC1A); end
        hold(4'b0100, 7'b0000001, 1);
        n_checks++; if (bad_pattern !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse_end: got %b expected 0", bad_pattern); end
        hold(4'b0011, 7'b0110000, 8);
        n_checks++; if (value !== 16'hDC1A) begin n_fail++; $display("FAIL overlap_value: got %h expected %h", value, 16'hDC1A); end
        n_checks++; if (digit_valid !== 4'b1011) begin n_fail++; $display("FAIL overlap_valid: got %b expected %b", digit_valid, 4'b1011); end
        n_checks++; if (bp_cnt !== 1) begin n_fail++; $display("FAIL overlap_bad_pulses: got %0d expected 1", bp_cnt); end
        n_checks++; if (fd_cnt !== 0) begin n_fail++; $display("FAIL overlap_frame_pulses: got %0d expected 0", fd_cnt); end
        $display("test_illegal_overlap done: value=%h valid=%b", value, digit_valid);
    endtask

    task automatic test_reset_mid_count();
        hold(4'b1000, 7'b0110011, 2);
        reset = 1'b1;
        hold(4'b1000, 7'b0110011, 1);
        reset = 1'b0;
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL midreset_value: got %h expected %h", value, 16'h0000); end
        hold(4'b1000, 7'b0110011, 2);
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL midreset_two: got %h expected %h", value, 16'h0000); end
        hold(4'b1000, 7'b0110011, 1);
        n_checks++; if (value !== 16'h0000) begin n_fail++; $display("FAIL midreset_three: got %h expected %h", value, 16'h0000); end
        hold(4'b1000, 7'b0110011, 1);
        n_checks++; if (value !== 16'h4000) begin n_fail++; $display("FAIL midreset_value4: got %h expected %h", value, 16'h4000); end
        n_checks++; if (digit_valid !== 4'b1000) begin n_fail++; $display("FAIL midreset_valid: got %b expected %b", digit_valid, 4'b1000); end
        $display("test_reset_mid_count done: value=%h valid=%b", value, digit_valid);
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_full_frame();
        test_glitch();
        test_illegal_overlap();
        test_reset_mid_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sevenseg_reader.md
Name: sevenseg_reader

Overview:
- Capture-side counterpart of the sevenseg display path.
- Monitors a time-multiplexed seven-segment bus: one-hot digit strobes plus a shared segment pattern.
- Waits until each strobed pattern has held stable, then converts it back to a hex nibble and rebuilds the displayed multi-digit value.
- Used as a self-checking monitor and loopback block beside display drivers.

Parameters:
- NDIGITS, 4, number of multiplexed digits (strobe width), range 1..8.
- STABLE_CYCLES, 4, consecutive identical cycles required before capture, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- digit_en  input  NDIGITS  digit strobe, active-high, legal only when one-hot.
- segments  input  7  pattern {a,b,c,d,e,f,g}, a = bit 6, active-high.
- value  output  4*NDIGITS  captured nibbles; digit i occupies bits [4i+3:4i].
- digit_valid  output  NDIGITS  bit i set when digit i holds a legally decoded nibble.
- frame_done  output  1  one-cycle pulse when every digit has been captured since the last pulse.
- bad_pattern  output  1  one-cycle pulse when a stable pattern is not a legal hex glyph.

Behaviour:
- Reset: reset=1 at a rising edge clears value, digit_valid, frame_done, bad_pattern, the seen mask, the stable counter and the previous-input registers, and sets state to WAIT. Reset mid-count discards the partial count.
- Legal glyph table (pattern -> nibble):
  - 1111110=0, 0110000=1, 1101101=2, 1111001=3
  - 0110011=4, 1011011=5, 1011111=6, 1110000=7
  - 1111111=8, 1110011=9, 1110111=A, 0011111=b
  - 1001110=C, 0111101=d, 1001111=E, 1000111=F
  - Every other pattern is illegal.
- "Same" means digit_en and segments both equal their values from the previous cycle.
- State machine:
  - WAIT: entered when digit_en is not one-hot (zero or multiple bits). Counter = 0, no capture. If digit_en is one-hot, go to COUNT with counter = 1.
  - COUNT:
    - If inputs are same, counter increments.
    - When counter would reach STABLE_CYCLES, capture and go to HELD.
    - If inputs change to another one-hot value, stay in COUNT with counter = 1.
    - If inputs become non-one-hot, go to WAIT.
  - HELD: no further capture while inputs are same. On any change, behave as COUNT (counter = 1) or WAIT (non-one-hot).
- Capture latency: outputs update at the rising edge that ends the STABLE_CYCLES-th identical cycle. The first captured value is therefore visible STABLE_CYCLES edges after the strobe first appears.
- Capture into digit i (i = index of the one-hot bit):
  - Legal pattern: value[4i+3:4i] <= nibble, digit_valid[i] <= 1, seen[i] <= 1.
  - Illegal pattern: nibble unchanged, digit_valid[i] <= 0, seen[i] unchanged, bad_pattern pulses for 1 cycle.
- frame_done: registered in the same edge as the capture that makes seen all-ones. In that edge seen clears to 0. frame_done is high for exactly that one cycle.
- Re-capture of an already-seen digit within a frame updates the value and does not double-count.
- Counter width is clog2(STABLE_CYCLES+1) and it saturates; it never wraps.
- Outputs change only on capture or reset. digit_valid bits never clear except by reset or an illegal capture.

Decomposition:
- Package sevenseg_pkg:
  - SEG_* localparams for the 16 glyphs.
  - typedef seg_t (logic [6:0]).
  - typedef nibble_t (logic [3:0]).
  - enum rd_state_t {WAIT, COUNT, HELD}.
- Sub-module seg_to_hex (combinational): segments -> nibble plus legal flag, a unique case over the package glyphs. All sequential logic stays in sevenseg_reader.

Test Plan:
- Reset then idle: reset=1 for 2 cycles, digit_en=0 -> value=0, digit_valid=0, no pulses for 20 cycles.
- Single digit: digit_en=0001, segments=1111001 held 4 cycles -> after 4th edge value[3:0]=3, digit_valid=0001. Holding 10 more cycles produces no further update.
- Full frame: cycle digits 0..3 with glyphs 1110111, 0011111, 1001110, 0111101, 4 cycles each -> value=16'hDCBA, digit_valid=1111, frame_done high exactly one cycle, coincident with the digit-3 capture.
- Glitch rejection: digit_en=0010, segments=1011011 for 3 cycles, then 1 cycle of 0110000, then 4 cycles of 0110000 -> no capture of 5; value[7:4]=1 after the 4th stable 0110000 cycle.
- Illegal/overlap: segments=0000001 held 4 cycles on digit 2 -> bad_pattern one pulse, digit_valid[2]=0. digit_en=0011 held 8 cycles -> no capture.
- Reset mid-count: 2 stable cycles, then reset=1, then 2 more stable cycles -> no capture; capture requires 4 fresh cycles after reset.
